// File: rtl/dt1_dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: size codes, FSM
// states, access owner and the store-lane formatting function.
package dt1_dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2
    } dmemState_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } dmemOwner_t;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } laneFmt_t;

    // Byte enables and replicated store data for a CPU store; size 11 behaves as word.
    function automatic laneFmt_t laneFormat(input logic [1:0] size,
                                            input logic [1:0] addrLo,
                                            input logic [DATA_W-1:0] wdata);
        laneFmt_t r;
        r.be    = 4'b1111;
        r.wdata = wdata;
        case (size)
            SIZE_BYTE: begin
                r.be    = 4'b0001 << addrLo;
                r.wdata = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                r.be    = addrLo[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        return r;
    endfunction

    // Half on an odd address or word not on a 4-byte boundary.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic r;
        r = 1'b0;
        if (size == SIZE_HALF) begin
            r = addrLo[0];
        end else if (size[1]) begin
            r = (addrLo != 2'b00);
        end
        return r;
    endfunction

endpackage

// File: rtl/dt1_dmem_lane_fmt.sv
// Combinational store-lane formatter: size and low address bits to byte
// enables plus replicated write data.
module dt1_dmem_lane_fmt
    import dt1_dmem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addrLo,
    input  logic [DATA_W-1:0] wdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdataRep
);

    laneFmt_t fmt;

    // Apply the shared lane-format rule.
    always_comb begin
        fmt      = laneFormat(size, addrLo, wdata);
        be       = fmt.be;
        wdataRep = fmt.wdata;
    end

endmodule

// File: rtl/dt1_dmem_arbiter.sv
// Data-memory arbiter between the CPU memory stage and a DMA port onto one
// req/gnt/rvalid SRAM, one access outstanding at a time.
// Optional build macro: DT1_DMEM_MISALIGN_CHECK_EN rejects misaligned CPU
// half/word accesses in IDLE instead of issuing them.
module dt1_dmem_arbiter
    import dt1_dmem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    input  logic [3:0]        dma_be,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              misalign_err
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    dmemState_t       state;
    dmemState_t       stateNext;
    dmemOwner_t       owner;
    logic [CNT_W-1:0] starveCnt;
    logic [3:0]       laneBe;
    logic [31:0]      laneWdata;
    logic             pickDma;
    logic             pickCpu;
    logic             cpuMisalign;
    logic             issueCpu;
    logic             startAccess;
    logic             misalignHit;
    logic             cpuDone;

    dt1_dmem_lane_fmt uLaneFmt (
        .size     (cpu_size),
        .addrLo   (cpu_addr[1:0]),
        .wdata    (cpu_wdata),
        .be       (laneBe),
        .wdataRep (laneWdata)
    );

`ifdef DT1_DMEM_MISALIGN_CHECK_EN
    assign cpuMisalign = isMisaligned(cpu_size, cpu_addr[1:0]);
`else
    assign cpuMisalign = 1'b0;
`endif

    // CPU has priority unless DMA has waited through STARVE_LIMIT CPU grants.
    assign pickDma     = dma_req & (~cpu_req | (starveCnt == CNT_W'(STARVE_LIMIT)));
    assign pickCpu     = cpu_req & ~pickDma;
    assign issueCpu    = pickCpu & ~cpuMisalign;
    assign startAccess = (state == ST_IDLE) & (issueCpu | pickDma);
    assign misalignHit = (state == ST_IDLE) & pickCpu & cpuMisalign;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (startAccess) stateNext = ST_ISSUE;
            ST_ISSUE:  if (mem_gnt) stateNext = mem_we ? ST_IDLE : ST_WAIT_R;
            ST_WAIT_R: if (mem_rvalid) stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // Per-state outputs and completion routing to the owner.
    always_comb begin
        mem_req      = 1'b0;
        cpuDone      = 1'b0;
        cpu_rvalid   = 1'b0;
        cpu_rdata    = 32'h0;
        dma_gnt      = 1'b0;
        dma_rvalid   = 1'b0;
        dma_rdata    = 32'h0;
        misalign_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (misalignHit) begin
                    cpuDone      = 1'b1;
                    misalign_err = 1'b1;
                    cpu_rvalid   = ~cpu_we;
                end
            end
            ST_ISSUE: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    if (owner == OWN_DMA) begin
                        dma_gnt = 1'b1;
                    end else begin
                        cpuDone = mem_we;
                    end
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    if (owner == OWN_DMA) begin
                        dma_rvalid = 1'b1;
                        dma_rdata  = mem_rdata;
                    end else begin
                        cpuDone    = 1'b1;
                        cpu_rvalid = 1'b1;
                        cpu_rdata  = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
        cpu_stall = cpu_req & ~cpuDone;
    end

    // Latch the winning request's fields and track DMA starvation.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_CPU;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            starveCnt <= '0;
        end else begin
            if (startAccess) begin
                if (pickDma) begin
                    owner     <= OWN_DMA;
                    mem_we    <= dma_we;
                    mem_addr  <= dma_addr & WORD_MASK;
                    mem_be    <= dma_be;
                    mem_wdata <= dma_wdata;
                end else begin
                    owner     <= OWN_CPU;
                    mem_we    <= cpu_we;
                    mem_addr  <= cpu_addr & WORD_MASK;
                    mem_be    <= cpu_we ? laneBe : 4'b1111;
                    mem_wdata <= laneWdata;
                end
            end
            if (!dma_req) begin
                starveCnt <= '0;
            end else if (startAccess && pickDma) begin
                starveCnt <= '0;
            end else if (startAccess && issueCpu && (starveCnt != CNT_W'(STARVE_LIMIT))) begin
                starveCnt <= starveCnt + CNT_W'(1);
            end
        end
    end

endmodule
